wb_reg_file: RTL
================

// Module: wb_reg_file
// PURPOSE
//  Register file at the receiving end of the writeback path: accepts the 32-bit
//  value chosen by the writeback data mux plus destination/enable from MAWB,
//  and serves two combinational read ports to the decode stage. Register 0 is
//  hardwired to zero. A write-retire counter exposes writeback activity.
// PARAMETERS
//  DATA_W    32   register width
//  ADDR_W    5    register index width; depth = 2**ADDR_W
//  CNT_W     16   width of retired-write counter
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       synchronous reset, active-low
//  WriteEnIn      in   1       write strobe from MAWB
//  WriteAddrIn    in   ADDR_W  destination register from MAWB
//  WriteDataIn    in   DATA_W  writeback value from data mux
//  ReadAddrAIn    in   ADDR_W  rs index from decode
//  ReadAddrBIn    in   ADDR_W  rt index from decode
//  ReadDataAOut   out  DATA_W  rs value
//  ReadDataBOut   out  DATA_W  rt value
//  WriteCountOut  out  CNT_W   number of committed non-zero-index writes
// BEHAVIOUR
//  - Reset: on rising clk with rst_n=0, every register and WriteCountOut -> 0;
//    any write presented that cycle is discarded. Takes effect after 1 edge.
//  - Write: on rising clk with rst_n=1, WriteEnIn=1, WriteAddrIn!=0:
//    reg[WriteAddrIn] <= WriteDataIn; WriteCountOut += 1. Latency 1 cycle.
//  - WriteAddrIn==0 with WriteEnIn=1: no state change, counter not incremented.
//  - WriteEnIn=0: no state change regardless of address/data.
//  - Counter wraps 2**CNT_W-1 -> 0 silently.
//  - Reads: combinational, ReadDataXOut = (addr==0) ? 0 : reg[addr].
//  - Both read ports may address the same register; both return identical value.
//  - Read of a register being written in the same cycle: see CONFIGURATION.
//  - Reset mid-operation: registers cleared on that edge; reads during reset
//    cycles return pre-edge contents until the clearing edge, 0 afterwards.
//  - No X propagation: all registers have defined reset values.
// CONFIGURATION
//  Macro WB_REG_FILE_BYPASS_EN:
//  - defined: if WriteEnIn=1, WriteAddrIn!=0, rst_n=1 and ReadAddrX==WriteAddrIn,
//    ReadDataXOut = WriteDataIn in the same cycle (write-through forwarding,
//    removes the WB->ID hazard). Index 0 still reads 0.
//  - undefined: reads return stored value only; new value visible the cycle
//    after the write edge (pipeline must stall/split-cycle externally).
// TESTING
//  1 rst_n=0 one edge, then read all 32 indices -> all 0, WriteCountOut=0.
//  2 write r5=0xDEADBEEF, next cycle ReadAddrA=5,ReadAddrB=5 -> both 0xDEADBEEF,
//    WriteCountOut=1.
//  3 write r0=0x12345678 -> ReadDataA(addr 0)=0, WriteCountOut unchanged.
//  4 same-cycle write r7=0xA5A5A5A5 and read r7 (r7 held 0x1) -> 0xA5A5A5A5
//    with WB_REG_FILE_BYPASS_EN, 0x00000001 without; both 0xA5A5A5A5 next cycle.
//  5 write r3=0x55 then assert rst_n=0 together with write r4=0x66 -> after
//    edge r3=0, r4=0, WriteCountOut=0.
//  6 CNT_W=4: 16 writes to r1..r16 -> WriteCountOut wraps to 0; r16 holds last.

Source files
------------

// File: rtl/wb_reg_file.sv
// wb_reg_file: writeback-stage register file with two combinational read ports
//
// Register 0 always reads as zero. A counter tracks committed writes to
// non-zero indices and wraps silently at 2**CNT_W.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset; clears all registers and the counter
//   WriteEnIn     write strobe
//   WriteAddrIn   destination register index
//   WriteDataIn   value to write
//   ReadAddrAIn   read port A index
//   ReadAddrBIn   read port B index
//   ReadDataAOut  read port A data (combinational)
//   ReadDataBOut  read port B data (combinational)
//   WriteCountOut committed non-zero-index write count
//
// Macro WB_REG_FILE_BYPASS_EN: when defined, a read that matches the register
// being written this cycle returns the incoming write data (write-through).
// When undefined, reads return only the stored contents.
module wb_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WriteEnIn,
    input  logic [ADDR_W-1:0] WriteAddrIn,
    input  logic [DATA_W-1:0] WriteDataIn,
    input  logic [ADDR_W-1:0] ReadAddrAIn,
    input  logic [ADDR_W-1:0] ReadAddrBIn,
    output logic [DATA_W-1:0] ReadDataAOut,
    output logic [DATA_W-1:0] ReadDataBOut,
    output logic [CNT_W-1:0]  WriteCountOut
);
    logic [DATA_W-1:0] r_regs [2**ADDR_W];
    logic [CNT_W-1:0]  r_count;
    logic              w_wr;

    assign w_wr = WriteEnIn && (WriteAddrIn != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) r_regs[i] <= '0;
            r_count <= '0;
        end else if (w_wr) begin
            r_regs[WriteAddrIn] <= WriteDataIn;
            r_count             <= r_count + 1'b1;
        end
    end

`ifdef WB_REG_FILE_BYPASS_EN
    logic w_fwd_a, w_fwd_b;
    // Forwarding is suppressed during reset because the write is discarded.
    assign w_fwd_a = rst_n && w_wr && (ReadAddrAIn == WriteAddrIn);
    assign w_fwd_b = rst_n && w_wr && (ReadAddrBIn == WriteAddrIn);
    assign ReadDataAOut = (ReadAddrAIn == '0) ? '0 : w_fwd_a ? WriteDataIn : r_regs[ReadAddrAIn];
    assign ReadDataBOut = (ReadAddrBIn == '0) ? '0 : w_fwd_b ? WriteDataIn : r_regs[ReadAddrBIn];
`else
    assign ReadDataAOut = (ReadAddrAIn == '0) ? '0 : r_regs[ReadAddrAIn];
    assign ReadDataBOut = (ReadAddrBIn == '0) ? '0 : r_regs[ReadAddrBIn];
`endif

    assign WriteCountOut = r_count;
endmodule
